slow_tick_bcd_timer: RTL and testbench
======================================

# slow_tick_bcd_timer

Consumes the divided clock `low_clock` from the frequency divider and drives a BCD up/down timer with start/pause/clear control. `low_clock` is synchronized into the `speed_clock` domain, and each rising edge becomes a one-cycle count-enable tick. All state is clocked by `speed_clock`; `low_clock` is never used as a clock. The block sits between the divider and the display/LED stage.

## Interface
- `DIGITS`, default 4: number of BCD digits (count width is 4*DIGITS).
- `speed_clock` input 1: system clock, 25 MHz.
- `reset` input 1: asynchronous, active-low.
- `low_clock` input 1: divided clock from the divider; treated as asynchronous data.
- `start` input 1: level, sampled each cycle; starts or resumes counting.
- `pause` input 1: level; freezes counting while in RUN.
- `clear` input 1: synchronous clear to IDLE with count 0.
- `dir` input 1: 0 = count up from 0, 1 = count down from `load`; sampled only on a start from IDLE or DONE.
- `load` input 4*DIGITS: BCD preset for down-count.
- `count` output 4*DIGITS: current BCD value.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE.
- `tick` output 1: registered one-cycle pulse per `low_clock` rising edge.

## Operation
- Synchronizer: three flops `s1`, `s2` and `s3`, all reset to 0. `tick` is registered from `s2 & ~s3`.
- State machine: IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- Priority, highest first: `reset`, `clear`, state transition, `tick`.
- Any state, `clear`=1: go to IDLE with `count`=0 on the next edge.
- IDLE or DONE, `start`=1:
  - `dir`=0 loads `count`=0 and goes to RUN.
  - `dir`=1 loads `count`=`load` and goes to RUN.
  - `dir`=1 with `load`=0 goes directly to DONE with `count`=0.
  - Any `load` digit greater than 9 is clamped to 9.
  - The latched direction is held until the next load.
- RUN, `pause`=1: go to PAUSED. A `tick` in the same cycle is discarded.
- RUN, `tick`=1, `pause`=0: increment or decrement `count` in BCD with per-digit carry/borrow.
  - Up-count: when the result is all 9s (9999 for `DIGITS`=4), go to DONE with `count` = all 9s.
  - Down-count: when the result is 0, go to DONE with `count`=0.
- PAUSED: ticks are ignored. `start`=1 with `pause`=0 returns to RUN without reloading.
- DONE: `count` holds. `start` restarts as described above.
- `start` held high in RUN has no effect. `pause` in IDLE or DONE is ignored.

## Timing
- Reset values: `count`=0, `running`=0, `done`=0, `tick`=0, state IDLE, `s1`/`s2`/`s3`=0. Reset takes effect immediately, including mid-count.
- `tick` latency: if `low_clock` is first sampled high at edge k, `tick` is high for the cycle following edge k+2. `count` updates at edge k+3.
- Exactly one `tick` per `low_clock` rising edge. No tick on falling edges.
- `running` and `done` are registered from the state and change on the same edge as the state.
- Control response: a `start`, `pause` or `clear` sampled at edge n takes effect in the state and `count` at edge n. Outputs are visible after edge n.

## Configuration
- `SLOW_TICK_BCD_TIMER_SEG7_EN` defined:
  - Adds output `seg` (7*DIGITS bits), active-low, segment order gfedcba, one group per digit.
  - Digit 0 drives the LSBs.
  - `seg` is decoded combinationally from `count`.
- Not defined: no `seg` port and no decoder logic. Behaviour is otherwise identical.

## Structure
- Package `slow_tick_timer_pkg`:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3.
  - BCD max digit constant 4'd9.
  - 7-segment decode function.
- Sub-module `slow_tick_sync`: 3-flop synchronizer plus rising-edge detector, producing `tick`. Reused by other consumers of the divider.

## Test plan
- Reset, then `low_clock` toggling every 4 cycles: `tick` pulses once per 8 cycles; `count` stays 0 in IDLE; `running`=0.
- `dir`=0, `start` pulse, then 12 ticks: `count`=0x0012. Decimal carry from 0x0009 to 0x0010 is exercised.
- `dir`=1, `load`=0x0003, start, then 3 ticks: `count` goes 2, 1, 0; `done`=1 on the edge reaching 0; further ticks leave `count`=0.
- Up-count preloaded via forced state near the top: 0x9998, then 2 ticks gives 0x9999 and `done`=1 on the first tick; the second tick is ignored.
- `pause` asserted in the same cycle as `tick` at `count`=0x0005: `count` stays 0x0005 in PAUSED. A later `start` resumes, and the next tick gives 0x0006.
- `reset` pulled low mid-count at 0x0042: all outputs return to 0 immediately. `clear` in DONE gives IDLE and 0 on the next edge. `load`=0x00A3 at start is clamped to 0x0093.

Source files
------------

// File: rtl/slow_tick_timer_pkg.sv
// Shared types and helpers for the slow-tick BCD timer and its consumers.
// Contents: timer state enum, BCD digit limit, active-low 7-segment decode.
package slow_tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low segments, bit order gfedcba; non-BCD codes blank the digit.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] on;
        on = 7'h00;
        case (digit)
            4'd0:    on = 7'h3f;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5b;
            4'd3:    on = 7'h4f;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6d;
            4'd6:    on = 7'h7d;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7f;
            4'd9:    on = 7'h6f;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/slow_tick_sync.sv
// Brings the divided low_clock into the speed_clock domain as a one-cycle tick.
// Ports: speed_clock, reset (async, active-low), low_clock (async data), tick.
module slow_tick_sync (
    input  logic speed_clock,
    input  logic reset,
    input  logic low_clock,
    output logic tick
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 holds the previous settled level
    // so s2 & ~s3 marks exactly one cycle per rising edge.
    always_ff @(posedge speed_clock or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= low_clock;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/slow_tick_bcd_timer.sv
// BCD up/down timer stepped by ticks derived from the divided low_clock.
// Ports: speed_clock, reset (async, active-low), low_clock, start, pause,
// clear, dir, load[4*DIGITS], count[4*DIGITS], running, done, tick.
// Macro SLOW_TICK_BCD_TIMER_SEG7_EN adds seg[7*DIGITS] (active-low gfedcba).
module slow_tick_bcd_timer
    import slow_tick_timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  speed_clock,
    input  logic                  reset,
    input  logic                  low_clock,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  dir,
    input  logic [4*DIGITS-1:0]   load,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  tick
`ifdef SLOW_TICK_BCD_TIMER_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int W = 4 * DIGITS;

    state_t       state;
    state_t       state_n;
    logic [W-1:0] count_n;
    logic         dir_q;
    logic         dir_n;

    logic [W-1:0] inc;
    logic [W-1:0] dec;
    logic [W-1:0] clamped;
    logic [W-1:0] nines;

    slow_tick_sync u_sync (
        .speed_clock (speed_clock),
        .reset       (reset),
        .low_clock   (low_clock),
        .tick        (tick)
    );

    // Ripple BCD increment/decrement, plus digit clamp of the preset.
    always_comb begin
        logic carry;
        logic borrow;
        logic [3:0] d;
        inc     = count;
        dec     = count;
        clamped = load;
        nines   = '0;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            nines[4*i +: 4] = BCD_MAX;
            if (carry) begin
                if (d >= BCD_MAX) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    dec[4*i +: 4] = BCD_MAX;
                end else begin
                    dec[4*i +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load[4*i +: 4] > BCD_MAX) begin
                clamped[4*i +: 4] = BCD_MAX;
            end
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        dir_n   = dir_q;
        if (clear) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dir_n = dir;
                        if (dir) begin
                            count_n = clamped;
                            state_n = (clamped == '0) ? DONE : RUN;
                        end else begin
                            count_n = '0;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    // Pause wins over a coincident tick; that tick is lost.
                    if (pause) begin
                        state_n = PAUSED;
                    end else if (tick) begin
                        if (dir_q) begin
                            count_n = dec;
                            if (dec == '0) state_n = DONE;
                        end else begin
                            count_n = inc;
                            if (inc == nines) state_n = DONE;
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge speed_clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            dir_q   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            dir_q   <= dir_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
        end
    end

`ifdef SLOW_TICK_BCD_TIMER_SEG7_EN
    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg7_decode(count[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_slow_tick_bcd_timer.sv
// Directed bench for slow_tick_bcd_timer with a decimal reference model
// and an expectation queue checked after each stimulus settles.
module tb_slow_tick_bcd_timer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic        speed_clock = 1'b0;
    logic        reset       = 1'b0;
    logic        low_clock   = 1'b0;
    logic        start       = 1'b0;
    logic        pause       = 1'b0;
    logic        clear       = 1'b0;
    logic        dir         = 1'b0;
    logic [15:0] load        = '0;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        tick;
`ifdef SLOW_TICK_BCD_TIMER_SEG7_EN
    logic [27:0] seg;
`endif

    slow_tick_bcd_timer #(.DIGITS(4)) dut (
        .speed_clock (speed_clock),
        .reset       (reset),
        .low_clock   (low_clock),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .dir         (dir),
        .load        (load),
        .count       (count),
        .running     (running),
        .done        (done),
        .tick        (tick)
`ifdef SLOW_TICK_BCD_TIMER_SEG7_EN
        ,
        .seg         (seg)
`endif
    );

    always #20 speed_clock = ~speed_clock;

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        run;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_seen = 0;

    int   m_state = M_IDLE;
    int   m_val   = 0;
    bit   m_dir   = 1'b0;

    always @(negedge speed_clock) if (tick === 1'b1) tick_seen++;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [15:0] b);
        int v;
        int mul;
        int d;
        v = 0;
        mul = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * mul;
            mul *= 10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.cnt = to_bcd(m_val);
        e.run = (m_state == M_RUN);
        e.dn  = (m_state == M_DONE);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".count"}, 32'(count), 32'(e.cnt));
            chk({e.tag, ".running"}, 32'(running), 32'(e.run));
            chk({e.tag, ".done"}, 32'(done), 32'(e.dn));
        end
    endtask

    task automatic m_tick();
        if (m_state == M_RUN) begin
            if (m_dir) begin
                m_val--;
                if (m_val == 0) m_state = M_DONE;
            end else begin
                m_val++;
                if (m_val == 9999) m_state = M_DONE;
            end
        end
    endtask

    task automatic do_start(input string tag, input bit d, input logic [15:0] ld);
        @(negedge speed_clock);
        start = 1'b1;
        dir   = d;
        load  = ld;
        if (m_state == M_IDLE || m_state == M_DONE) begin
            m_dir   = d;
            m_val   = d ? clamp_val(ld) : 0;
            m_state = (d && m_val == 0) ? M_DONE : M_RUN;
        end else if (m_state == M_PAUSED) begin
            m_state = M_RUN;
        end
        push(tag);
        @(negedge speed_clock);
        start = 1'b0;
        check_out();
    endtask

    task automatic do_clear(input string tag);
        @(negedge speed_clock);
        clear   = 1'b1;
        m_state = M_IDLE;
        m_val   = 0;
        push(tag);
        @(negedge speed_clock);
        clear = 1'b0;
        check_out();
    endtask

    // One low_clock pulse; optionally assert pause in the tick cycle.
    task automatic do_tick(input string tag, input bit with_pause);
        @(negedge speed_clock);
        low_clock = 1'b1;
        if (with_pause && m_state == M_RUN) m_state = M_PAUSED;
        else m_tick();
        push(tag);
        @(negedge speed_clock);
        low_clock = 1'b0;
        @(negedge speed_clock);
        @(negedge speed_clock);
        chk({tag, ".tick"}, 32'(tick), 32'd1);
        if (with_pause) pause = 1'b1;
        @(negedge speed_clock);
        pause = 1'b0;
        check_out();
    endtask

    task automatic burst(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge speed_clock);
            low_clock = 1'b1;
            m_tick();
            @(negedge speed_clock);
            low_clock = 1'b0;
        end
        push(tag);
        repeat (4) @(negedge speed_clock);
        check_out();
    endtask

    initial begin
        // Reset state
        push("reset");
        repeat (3) @(negedge speed_clock);
        check_out();
        chk("reset.tick", 32'(tick), 32'd0);
        reset = 1'b1;

        // Idle ticking: low_clock period 8 cycles, 4 rising edges
        tick_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge speed_clock);
            low_clock = 1'b1;
            repeat (4) @(negedge speed_clock);
            low_clock = 1'b0;
            repeat (3) @(negedge speed_clock);
        end
        push("idle");
        repeat (4) @(negedge speed_clock);
        chk("idle.tick_count", 32'(tick_seen), 32'd4);
        check_out();

        // Up count through the 9 -> 10 carry to 12
        do_start("up_start", 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) do_tick("up_tick", 1'b0);
        chk("up.count12", 32'(count), 32'h0012);
        do_clear("up_clear");

        // Down count 3 -> 0, then further ticks are ignored
        do_start("dn_start", 1'b1, 16'h0003);
        for (int i = 0; i < 5; i++) do_tick("dn_tick", 1'b0);

        // Pause coinciding with a tick at 5, resume, continue to 6
        do_start("pz_start", 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) do_tick("pz_tick", 1'b0);
        do_tick("pz_pause", 1'b1);
        do_tick("pz_held", 1'b0);
        do_start("pz_resume", 1'b0, 16'h0000);
        do_tick("pz_after", 1'b0);
        chk("pz.count6", 32'(count), 32'h0006);

        // Asynchronous reset mid-count at 42
        do_clear("rs_clear");
        do_start("rs_start", 1'b0, 16'h0000);
        burst("rs_42", 42);
        @(negedge speed_clock);
        reset   = 1'b0;
        m_state = M_IDLE;
        m_val   = 0;
        push("rs_async");
        #1;
        check_out();
        chk("rs_async.tick", 32'(tick), 32'd0);
        @(negedge speed_clock);
        reset = 1'b1;

        // Pause in IDLE has no effect
        @(negedge speed_clock);
        pause = 1'b1;
        push("idle_pause");
        @(negedge speed_clock);
        pause = 1'b0;
        check_out();

        // Down start with load 0 goes straight to DONE
        do_start("zero_load", 1'b1, 16'h0000);

        // Out-of-range digit clamped: A3 -> 93
        do_start("clamp", 1'b1, 16'h00a3);
        do_tick("clamp_tick", 1'b0);

        // Up count to the top: 9998, then 9999 with done, then held
        do_clear("top_clear");
        do_start("top_start", 1'b0, 16'h0000);
        burst("top_9998", 9998);
        do_tick("top_9999", 1'b0);
        do_tick("top_hold", 1'b0);
        do_clear("done_clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
